pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter register and next-PC selector for the 9-bit CPU fetch stage.
//  Holds the current PC, which drives the instruction-memory address. Each cycle it
//  loads PC+1, a relative branch target or an absolute jump target. It also tracks
//  run/stall/halt state so that fetch starts on command and stops cleanly.
// PARAMETERS
//  PC_W        10   PC / instruction-address width
//  OFF_W       8    signed branch-offset width (two's complement)
//  START_ADDR  0    PC value loaded on reset and on start
// PORTS
//  clk          in   1      rising-edge clock; sole clock of the block
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      pulse: begin fetching at START_ADDR (IDLE/HALT only)
//  stall        in   1      hold PC this cycle (hazard from decode)
//  halt         in   1      stop fetch after current PC (decoded halt instr)
//  branch_en    in   1      take relative branch this cycle
//  branch_off   in   OFF_W  signed offset, target = pc + sext(branch_off)
//  jump_en      in   1      take absolute jump this cycle
//  jump_addr    in   PC_W   absolute target
//  pc           out  PC_W   current PC = imem address
//  pc_plus1     out  PC_W   pc+1 mod 2^PC_W, combinational (link value)
//  fetch_valid  out  1      imem output at pc is a valid instruction this cycle
//  done         out  1      high in HALT state
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, pc=START_ADDR, fetch_valid=0, done=0.
//  FSM states: IDLE, RUN, HALT (encoded in shared package).
//   IDLE: pc held, fetch_valid=0; start=1 -> RUN next cycle, pc=START_ADDR.
//   RUN : fetch_valid=1; next-PC priority (registered, 1-cycle latency):
//         halt > jump_en > branch_en > stall > increment.
//         halt=1 -> HALT, pc held. jump -> pc=jump_addr. branch -> pc=pc+sext(off).
//         stall -> pc held. Otherwise pc=pc+1.
//   HALT: pc frozen, fetch_valid=0, done=1; start=1 -> RUN, pc=START_ADDR.
//  Inputs other than start are ignored in IDLE/HALT; start is ignored in RUN.
//  Arithmetic is modulo 2^PC_W, with no overflow flag:
//   1023+1 -> 0; branch 5 + (-8) -> 1021; 1020 + 7 -> 3.
//  Simultaneous jump_en & branch_en: the jump wins.
//   jump/branch with stall: the redirect wins (flush overrides hazard).
//  halt together with jump/branch: halt wins and pc is not updated.
//  reset_n asserted mid-RUN: immediate return to IDLE/START_ADDR, no clock needed.
//   Deassertion is synchronised externally.
//  pc_plus1 is valid in all states, including IDLE.
// STRUCTURE
//  cpu_pkg: PC_W, OFF_W, START_ADDR constants; typedef enum fetch_state_t
//   {IDLE, RUN, HALT}; typedef logic [PC_W-1:0] pc_t.
//  Sub-module pc_target_adder: pc + sign-extended offset, mod 2^PC_W (combinational).
//  The +1 path uses the existing pc_increment block, checked over the full 10-bit
//   range (carry chain through bit 9).
//  Top level: state register, pc register, priority next-PC mux.
// TESTING
//  1 reset_n=0 mid-run with pc=0x123 -> pc=0, fetch_valid=0, done=0 same cycle.
//  2 start, then 4 free-run cycles -> pc 0,1,2,3,4.
//    Preload pc=1023 via jump -> next pc=0 (wrap).
//  3 pc=5, branch_en, off=8'hF8 -> pc=1021.
//    pc=1020, off=7 -> pc=3. pc=10, jump and branch (off=1) together, jump_addr=200 -> pc=200.
//  4 pc=40, stall for 3 cycles -> pc stays 40.
//    stall+branch off=2 -> pc=42; then increments to 43.
//  5 pc=77, halt+jump_en -> HALT, pc=77, done=1, fetch_valid=0.
//    start -> RUN, pc=0, done=0.
//  6 Random stimulus vs reference model: pc matches model each cycle;
//    pc_plus1==pc+1 mod 1024 for all 1024 pc values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: address/offset widths, reset PC and FSM encoding.
package cpu_pkg;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t START_ADDR = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_increment.sv
// Sequential-address incrementer; wraps modulo 2^W with no carry out.
module pc_increment #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = a + W'(1);

endmodule

// File: rtl/pc_target_adder.sv
// Relative branch target: pc plus sign-extended offset, modulo 2^PC_W.
module pc_target_adder #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] off,
    output logic [PC_W-1:0]  target
);

    logic [PC_W-1:0] off_ext;

    assign off_ext = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
    assign target  = pc + off_ext;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter with run/halt control and priority next-PC select.
//
//   state | meaning
//   IDLE  | out of reset, waiting for start; no fetch
//   RUN   | fetching at pc every cycle, pc advances/redirects
//   HALT  | halt instruction seen; pc frozen, done asserted, waits for start
module pc_fetch_ctrl
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_en,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             jump_en,
    input  pc_t              jump_addr,
    output pc_t              pc,
    output pc_t              pc_plus1,
    output logic             fetch_valid,
    output logic             done
);

    fetch_state_t state, state_nxt;
    pc_t          pc_nxt;
    pc_t          branch_target;

    pc_increment #(.W(PC_W)) u_inc (
        .a (pc),
        .y (pc_plus1)
    );

    pc_target_adder #(.PC_W(PC_W), .OFF_W(OFF_W)) u_tgt (
        .pc     (pc),
        .off    (branch_off),
        .target (branch_target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= START_ADDR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Redirects beat stall: a taken jump/branch flushes the hazarding instruction.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        fetch_valid = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE, HALT: begin
                done = (state == HALT);
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                end
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (halt) begin
                    state_nxt = HALT;
                end else if (jump_en) begin
                    pc_nxt = jump_addr;
                end else if (branch_en) begin
                    pc_nxt = branch_target;
                end else if (!stall) begin
                    pc_nxt = pc_plus1;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized checks of pc_fetch_ctrl against hand-computed values and a small model.
module tb_pc_fetch_ctrl;
    import cpu_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start, stall, halt, branch_en, jump_en;
    logic [OFF_W-1:0] branch_off;
    pc_t              jump_addr;
    pc_t              pc, pc_plus1;
    logic             fetch_valid, done;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .fetch_valid (fetch_valid),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt = 0; branch_en = 0; jump_en = 0;
        branch_off = '0; jump_addr = '0;
    endtask

    task automatic jump_to(input int a);
        jump_en = 1; jump_addr = pc_t'(a);
        tick();
        jump_en = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        #3;
        n_cmp++; if (pc !== 10'd0) begin n_bad++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        n_cmp++; if (fetch_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got fv=%b done=%b expected 0 0", fetch_valid, done); end
        n_cmp++; if (pc_plus1 !== 10'd1) begin n_bad++; $display("FAIL reset_plus1: got %0d expected 1", pc_plus1); end
        tick();
        reset_n = 1;
        jump_en = 1; jump_addr = 10'd55; branch_en = 1; branch_off = 8'd3;
        tick(); tick();
        n_cmp++; if (pc !== 10'd0 || fetch_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ignore: got pc=%0d fv=%b expected 0 0", pc, fetch_valid); end
        clear_inputs();
    endtask

    task automatic test_run();
        start = 1;
        tick();
        start = 0;
        n_cmp++; if (pc !== 10'd0 || fetch_valid !== 1'b1) begin n_bad++; $display("FAIL start_run: got pc=%0d fv=%b expected 0 1", pc, fetch_valid); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (pc !== pc_t'(i)) begin n_bad++; $display("FAIL free_run: got %0d expected %0d", pc, i); end
        end
        jump_to(1023);
        n_cmp++; if (pc !== 10'd1023 || pc_plus1 !== 10'd0) begin n_bad++; $display("FAIL jump_1023: got pc=%0d p1=%0d expected 1023 0", pc, pc_plus1); end
        tick();
        n_cmp++; if (pc !== 10'd0) begin n_bad++; $display("FAIL wrap: got %0d expected 0", pc); end
    endtask

    task automatic test_branch();
        jump_to(5);
        branch_en = 1; branch_off = 8'hF8;
        tick();
        n_cmp++; if (pc !== 10'd1021) begin n_bad++; $display("FAIL branch_neg: got %0d expected 1021", pc); end
        branch_en = 0;
        jump_to(1020);
        branch_en = 1; branch_off = 8'd7;
        tick();
        n_cmp++; if (pc !== 10'd3) begin n_bad++; $display("FAIL branch_wrap: got %0d expected 3", pc); end
        branch_en = 0;
        jump_to(10);
        jump_en = 1; jump_addr = 10'd200; branch_en = 1; branch_off = 8'd1;
        tick();
        n_cmp++; if (pc !== 10'd200) begin n_bad++; $display("FAIL jump_over_branch: got %0d expected 200", pc); end
        clear_inputs();
    endtask

    task automatic test_stall();
        jump_to(40);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pc !== 10'd40) begin n_bad++; $display("FAIL stall_hold: got %0d expected 40", pc); end
        end
        branch_en = 1; branch_off = 8'd2;
        tick();
        n_cmp++; if (pc !== 10'd42) begin n_bad++; $display("FAIL stall_branch: got %0d expected 42", pc); end
        clear_inputs();
        tick();
        n_cmp++; if (pc !== 10'd43) begin n_bad++; $display("FAIL post_stall: got %0d expected 43", pc); end
        start = 1;
        tick();
        start = 0;
        n_cmp++; if (pc !== 10'd44) begin n_bad++; $display("FAIL start_in_run: got %0d expected 44", pc); end
    endtask

    task automatic test_halt();
        jump_to(77);
        halt = 1; jump_en = 1; jump_addr = 10'd300;
        tick();
        clear_inputs();
        n_cmp++; if (pc !== 10'd77 || done !== 1'b1 || fetch_valid !== 1'b0) begin n_bad++; $display("FAIL halt: got pc=%0d done=%b fv=%b expected 77 1 0", pc, done, fetch_valid); end
        jump_en = 1; jump_addr = 10'd9; stall = 1;
        tick(); tick();
        clear_inputs();
        n_cmp++; if (pc !== 10'd77 || done !== 1'b1) begin n_bad++; $display("FAIL halt_frozen: got pc=%0d done=%b expected 77 1", pc, done); end
        start = 1;
        tick();
        start = 0;
        n_cmp++; if (pc !== 10'd0 || done !== 1'b0 || fetch_valid !== 1'b1) begin n_bad++; $display("FAIL restart: got pc=%0d done=%b fv=%b expected 0 0 1", pc, done, fetch_valid); end
    endtask

    task automatic test_reset_mid_run();
        jump_to(12'h123);
        #2;
        reset_n = 0;
        #1;
        n_cmp++; if (pc !== 10'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL async_reset: got pc=%0d fv=%b done=%b expected 0 0 0", pc, fetch_valid, done); end
        tick();
        reset_n = 1;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic test_plus1_sweep();
        for (int i = 0; i < 1024; i++) begin
            jump_en = 1; jump_addr = pc_t'(i);
            tick();
            n_cmp++; if (pc !== pc_t'(i)) begin n_bad++; $display("FAIL sweep_pc: got %0d expected %0d", pc, i); end
            n_cmp++; if (pc_plus1 !== pc_t'((i + 1) % 1024)) begin n_bad++; $display("FAIL sweep_plus1: got %0d expected %0d", pc_plus1, (i + 1) % 1024); end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int m_pc;
        int m_st;   // 0 idle, 1 run, 2 halt
        reset_n = 0;
        #2;
        reset_n = 1;
        m_pc = 0; m_st = 0;
        for (int c = 0; c < 400; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            halt       = ($urandom_range(0, 15) == 0);
            branch_en  = ($urandom_range(0, 4) == 0);
            jump_en    = ($urandom_range(0, 6) == 0);
            branch_off = 8'($urandom);
            jump_addr  = 10'($urandom);
            if (m_st != 1) begin
                if (start) begin m_st = 1; m_pc = 0; end
            end else if (halt) m_st = 2;
            else if (jump_en) m_pc = int'(jump_addr);
            else if (branch_en) m_pc = (m_pc + int'($signed(branch_off))) & 1023;
            else if (!stall) m_pc = (m_pc + 1) % 1024;
            tick();
            n_cmp++; if (pc !== pc_t'(m_pc)) begin n_bad++; $display("FAIL rand_pc cycle %0d: got %0d expected %0d", c, pc, m_pc); end
            n_cmp++; if (fetch_valid !== (m_st == 1) || done !== (m_st == 2)) begin n_bad++; $display("FAIL rand_flags cycle %0d: got fv=%b done=%b expected %b %b", c, fetch_valid, done, m_st == 1, m_st == 2); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_run();
        test_branch();
        test_stall();
        test_halt();
        test_reset_mid_run();
        test_plus1_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
